cpu_execution_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the execution stage, alongside the single-cycle ALU. It implements MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the architectural HI/LO registers. Multiply uses shift-add and divide uses restoring division, one bit per cycle. A start/busy/done handshake lets the pipeline stall on HI/LO consumers, and a flush input aborts work on exceptions.

---
 rtl/cpu_execution_muldiv_if.sv | 26 ++
 rtl/cpu_execution_muldiv.sv | 192 +++++++++++++++++++
 tb/tb_cpu_execution_muldiv.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_execution_muldiv_if.sv
// Handshake and result bus between the execution stage and the mul/div unit.
// The pipeline drives the request side (master); the unit drives status and HI/LO (slave).
interface cpu_execution_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct;
  logic [WIDTH-1:0] oper_a;
  logic [WIDTH-1:0] oper_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             badfunct;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, oper_a, oper_b, flush,
    input  busy, done, badfunct, hi, lo
  );

  modport slave (
    input  start, funct, oper_a, oper_b, flush,
    output busy, done, badfunct, hi, lo
  );
endinterface

// File: rtl/cpu_execution_muldiv.sv
// Iterative MIPS mult/div unit owning HI/LO: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are zero.
module cpu_execution_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                   clk_i,
  input logic                   rst_i,
  cpu_execution_muldiv_if.slave md_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic               psign_q, psign_d;
  logic               rsign_q, rsign_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               bad_q, bad_d;
  logic               busy_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     rem_sh, trial;
  logic [2*WIDTH-1:0] div_next, mul_next, prod_neg;
  logic [WIDTH-1:0]   quo, rem;
  logic               last_iter, mul_stop;

  always_comb begin
    a_neg = ~md_if.funct[0] & md_if.oper_a[WIDTH-1];
    b_neg = ~md_if.funct[0] & md_if.oper_b[WIDTH-1];
    abs_a = a_neg ? -md_if.oper_a : md_if.oper_a;
    abs_b = b_neg ? -md_if.oper_b : md_if.oper_b;
  end

  // Restoring step: {rem, next dividend bit} minus divisor; quotient bits shift in at the bottom.
  assign rem_sh   = prod_q[2*WIDTH-1:WIDTH-1];
  assign trial    = rem_sh - {1'b0, b_q};
  assign div_next = trial[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  assign mul_next  = b_q[0] ? (prod_q + mcand_q) : prod_q;
  assign prod_neg  = -prod_q;
  assign quo       = prod_q[WIDTH-1:0];
  assign rem       = prod_q[2*WIDTH-1:WIDTH];
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign mul_stop  = last_iter || (EARLY_OUT && (b_q[WIDTH-1:1] == '0));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    psign_d  = psign_q;
    rsign_d  = rsign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    bad_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_if.start) begin
          case (md_if.funct)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_d  = S_ITER;
              cnt_d    = '0;
              is_div_d = md_if.funct[1];
              dz_d     = md_if.funct[1] && (md_if.oper_b == '0);
              psign_d  = a_neg ^ b_neg;
              rsign_d  = a_neg;
              mcand_d  = {{WIDTH{1'b0}}, abs_a};
              b_d      = abs_b;
              // Divide-by-zero keeps the raw dividend for the HI write.
              if (!md_if.funct[1])
                prod_d = '0;
              else if (md_if.oper_b == '0)
                prod_d = {{WIDTH{1'b0}}, md_if.oper_a};
              else
                prod_d = {{WIDTH{1'b0}}, abs_a};
            end
            3'b100: begin
              hi_d   = md_if.oper_a;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = md_if.oper_a;
              done_d = 1'b1;
            end
            default: bad_d = 1'b1;
          endcase
        end
      end
      S_ITER: begin
        if (dz_q) begin
          hi_d    = prod_q[WIDTH-1:0];
          lo_d    = '1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (is_div_q) begin
          prod_d = div_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_iter) state_d = S_FIX;
        end else begin
          prod_d  = mul_next;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (mul_stop) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = psign_q ? -quo : quo;
          hi_d = rsign_q ? -rem : rem;
        end else begin
          hi_d = psign_q ? prod_neg[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
          lo_d = psign_q ? prod_neg[WIDTH-1:0] : prod_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a start presented in the same cycle.
    if (md_if.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      bad_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      psign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      bad_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      psign_q  <= psign_d;
      rsign_q  <= rsign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      bad_q    <= bad_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign md_if.busy     = busy_q;
  assign md_if.done     = done_q;
  assign md_if.badfunct = bad_q;
  assign md_if.hi       = hi_q;
  assign md_if.lo       = lo_q;

endmodule

// File: tb/tb_cpu_execution_muldiv.sv
// Directed-vector bench for cpu_execution_muldiv (WIDTH=32, early-out disabled).
module tb_cpu_execution_muldiv;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  cpu_execution_muldiv_if #(.WIDTH(W)) md_if ();

  cpu_execution_muldiv #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .md_if (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Presents one start cycle; returns just after the accepting edge.
  task automatic start_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    md_if.start  = 1'b1;
    md_if.funct  = f;
    md_if.oper_a = a;
    md_if.oper_b = b;
    @(posedge clk); #1;
    md_if.start  = 1'b0;
  endtask

  // n = cycles from the start cycle to the done cycle; nb = cycles busy was seen high.
  task automatic wait_done(output int n, output int nb);
    n  = 1;
    nb = md_if.busy ? 1 : 0;
    while (!md_if.done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (md_if.busy) nb++;
    end
    if (!md_if.done) check("done_timeout", 64'(md_if.done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_n, input int exp_nb,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int n, nb;
    start_op(f, a, b);
    wait_done(n, nb);
    check({tag, "_lat"}, 64'(n), 64'(exp_n));
    check({tag, "_busy"}, 64'(nb), 64'(exp_nb));
    check({tag, "_hi"}, 64'(md_if.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(md_if.lo), 64'(exp_lo));
  endtask

  initial begin
    int n, nb, dcnt;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    md_if.start  = 1'b0;
    md_if.funct  = 3'b000;
    md_if.oper_a = '0;
    md_if.oper_b = '0;
    md_if.flush  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(md_if.busy), 64'd0);
    check("rst_done", 64'(md_if.done), 64'd0);
    check("rst_bad",  64'(md_if.badfunct), 64'd0);
    check("rst_hi",   64'(md_if.hi), 64'd0);
    check("rst_lo",   64'(md_if.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 33, 32'hFFFF_FFFE, 32'h0000_0001);
    @(posedge clk); #1;
    check("done_pulse_width", 64'(md_if.done), 64'd0);
    run_op("mult_neg3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 34, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 34, 33, 32'd2, 32'd14);
    run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 34, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE, 34, 33, 32'd1, 32'hFFFF_FFFD);
    run_op("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 34, 33, 32'h0, 32'h8000_0000);
    run_op("mult_min_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 34, 33, 32'h4000_0000, 32'h0);
    run_op("div_by_zero", 3'b010, 32'h0000_1234, 32'h0, 2, 1, 32'h0000_1234, 32'hFFFF_FFFF);

    // Illegal funct: one-cycle badfunct, nothing else moves.
    start_op(3'b110, 32'hDEAD_BEEF, 32'h1);
    check("bad_pulse", 64'(md_if.badfunct), 64'd1);
    check("bad_busy",  64'(md_if.busy), 64'd0);
    @(posedge clk); #1;
    check("bad_clear", 64'(md_if.badfunct), 64'd0);
    check("bad_hi", 64'(md_if.hi), 64'h0000_1234);
    check("bad_lo", 64'(md_if.lo), 64'hFFFF_FFFF);

    run_op("mthi", 3'b100, 32'hA5A5_A5A5, 32'h0, 1, 0, 32'hA5A5_A5A5, 32'hFFFF_FFFF);

    // Flush ten cycles into a multiply.
    start_op(3'b000, 32'd2, 32'd3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    md_if.flush = 1'b1;
    @(posedge clk); #1;
    md_if.flush = 1'b0;
    check("flush_busy", 64'(md_if.busy), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_if.done) dcnt++;
      @(posedge clk); #1;
    end
    check("flush_no_done", 64'(dcnt), 64'd0);
    check("flush_hi", 64'(md_if.hi), 64'hA5A5_A5A5);
    check("flush_lo", 64'(md_if.lo), 64'hFFFF_FFFF);

    // Flush and start together: start must not be taken.
    @(negedge clk);
    md_if.start  = 1'b1;
    md_if.funct  = 3'b100;
    md_if.oper_a = 32'h1234_5678;
    md_if.flush  = 1'b1;
    @(posedge clk); #1;
    md_if.start = 1'b0;
    md_if.flush = 1'b0;
    check("flush_start_done", 64'(md_if.done), 64'd0);
    check("flush_start_hi", 64'(md_if.hi), 64'hA5A5_A5A5);

    run_op("mtlo", 3'b101, 32'h0F0F_0F0F, 32'h0, 1, 0, 32'hA5A5_A5A5, 32'h0F0F_0F0F);

    // Second start while busy is dropped.
    start_op(3'b000, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    start_op(3'b011, 32'd100, 32'd7);
    wait_done(n, nb);
    check("ignore_lat", 64'(n + 5), 64'd34);
    check("ignore_hi", 64'(md_if.hi), 64'd0);
    check("ignore_lo", 64'(md_if.lo), 64'd12);

    // Back-to-back start in the done cycle.
    @(negedge clk);
    md_if.start  = 1'b1;
    md_if.funct  = 3'b101;
    md_if.oper_a = 32'h0000_0077;
    @(posedge clk); #1;
    md_if.start = 1'b0;
    check("b2b_done", 64'(md_if.done), 64'd1);
    check("b2b_lo", 64'(md_if.lo), 64'h77);

    // Reset twenty cycles into a divide.
    start_op(3'b010, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(md_if.busy), 64'd0);
    check("midrst_hi", 64'(md_if.hi), 64'd0);
    check("midrst_lo", 64'(md_if.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (md_if.done) dcnt++;
    end
    check("midrst_no_done", 64'(dcnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
